// File: rtl/rf_arb_pkg.sv
// Shared widths, defaults and FIFO entry type for the register-file write arbiter.
// Included by the FIFO, the MDU result interface and the top level.
package rf_arb_pkg;

  localparam int REG_AW               = 5;
  localparam int DATA_W               = 32;
  localparam int NUM_REGS             = 32;
  localparam int DEFAULT_DEPTH        = 2;
  localparam int DEFAULT_STARVE_LIMIT = 4;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  // One-hot register mask; $0 maps to an empty mask so it can never become pending.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] a);
    logic [NUM_REGS-1:0] mask;
    if (a == 5'd0) begin
      mask = 32'd0;
    end else begin
      mask = 32'd1 << a;
    end
    return mask;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// MDU result channel: valid/ready handshake carrying a destination register and data.
// The MDU drives the master side, the arbiter consumes through the slave side.
interface rf_write_arbiter_if;
  import rf_arb_pkg::*;

  logic              m_valid;
  logic              m_ready;
  logic [REG_AW-1:0] m_addr;
  logic [DATA_W-1:0] m_data;

  modport master (
    output m_valid,
    output m_addr,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_addr,
    input  m_data,
    output m_ready
  );

endinterface

// File: rtl/rf_result_fifo.sv
// DEPTH-entry synchronous FIFO buffering MDU results until a free write slot appears.
// Pointers wrap naturally (DEPTH is a power of two); the occupancy count tells full from empty.
module rf_result_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  fifo_entry_t din,
  output logic        full,
  output logic        empty,
  output fifo_entry_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fifo_entry_t   mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == CW'(0));
  assign head  = mem_r[rd_ptr_r];

  // Qualify requests: a push on a full FIFO is only legal alongside a pop.
  always_comb begin
    do_pop_s  = 1'b0;
    do_push_s = 1'b0;
    if (pop && !empty) begin
      do_pop_s = 1'b1;
    end else begin
      do_pop_s = 1'b0;
    end
    if (push && (!full || do_pop_s)) begin
      do_push_s = 1'b1;
    end else begin
      do_push_s = 1'b0;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_r <= PW'(0);
      wr_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between pipeline writeback and buffered MDU results,
// tracks registers awaiting MDU results and requests a pipeline hold when drains starve.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                p_wr,
  input  logic [REG_AW-1:0]   p_addr,
  input  logic [DATA_W-1:0]   p_data,
  rf_write_arbiter_if.slave   mdu,
  input  logic                issue_valid,
  input  logic [REG_AW-1:0]   issue_addr,
  input  logic [REG_AW-1:0]   rs_addr,
  input  logic [REG_AW-1:0]   rt_addr,
  input  logic [REG_AW-1:0]   rd_addr,
  output logic                stall,
  output logic                p_hold,
  output logic                wr,
  output logic [REG_AW-1:0]   addr3,
  output logic [DATA_W-1:0]   data3,
  output logic [NUM_REGS-1:0] pending
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic                push_s;
  logic                pop_s;
  fifo_entry_t         din_s;
  fifo_entry_t         head_s;
  logic [NUM_REGS-1:0] set_mask_s;
  logic [NUM_REGS-1:0] clr_mask_s;
  logic [NUM_REGS-1:0] pending_r;
  logic [CNT_W-1:0]    starve_cnt_r;
  logic                starve_hit_s;
  logic                p_hold_r;

  assign din_s = '{addr: mdu.m_addr, data: mdu.m_data};

  rf_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (din_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .head  (head_s)
  );

  // Write-port mux: pipeline first, FIFO head only in otherwise idle slots, quiet in reset.
  always_comb begin
    wr    = 1'b0;
    addr3 = 5'd0;
    data3 = 32'd0;
    pop_s = 1'b0;
    if (!reset) begin
      wr    = 1'b0;
      pop_s = 1'b0;
    end else if (p_wr) begin
      wr    = 1'b1;
      addr3 = p_addr;
      data3 = p_data;
    end else if (!fifo_empty_s) begin
      wr    = 1'b1;
      addr3 = head_s.addr;
      data3 = head_s.data;
      pop_s = 1'b1;
    end else begin
      wr    = 1'b0;
      pop_s = 1'b0;
    end
  end

  // A full FIFO can still accept when its head leaves in the same cycle.
  always_comb begin
    mdu.m_ready = 1'b0;
    push_s      = 1'b0;
    if (!fifo_full_s || pop_s) begin
      mdu.m_ready = 1'b1;
    end else begin
      mdu.m_ready = 1'b0;
    end
    if (mdu.m_valid && mdu.m_ready) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  // Scoreboard masks: issue sets, a drained head clears.
  always_comb begin
    set_mask_s = 32'd0;
    clr_mask_s = 32'd0;
    if (issue_valid) begin
      set_mask_s = reg_onehot(issue_addr);
    end else begin
      set_mask_s = 32'd0;
    end
    if (pop_s) begin
      clr_mask_s = reg_onehot(head_s.addr);
    end else begin
      clr_mask_s = 32'd0;
    end
  end

  // Pending scoreboard; the set is applied last so a same-cycle re-issue survives the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_r <= 32'd0;
    end else begin
      pending_r <= (pending_r & ~clr_mask_s) | set_mask_s;
    end
  end

  assign starve_hit_s = (starve_cnt_r == CNT_W'(STARVE_LIMIT));

  // Starvation counter: counts blocked drain cycles, restarts on any drain, empty or hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_r <= CNT_W'(0);
      p_hold_r     <= 1'b0;
    end else begin
      p_hold_r <= starve_hit_s;
      if (fifo_empty_s || pop_s || starve_hit_s) begin
        starve_cnt_r <= CNT_W'(0);
      end else if (p_wr) begin
        starve_cnt_r <= starve_cnt_r + CNT_W'(1);
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end
  end

  assign stall   = pending_r[rs_addr] | pending_r[rt_addr] | pending_r[rd_addr];
  assign p_hold  = p_hold_r;
  assign pending = pending_r;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized scoreboard bench for rf_write_arbiter against a queue-based reference model.
module tb_rf_write_arbiter;
  import rf_arb_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_wr;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic        stall, p_hold, wr;
  logic [4:0]  addr3;
  logic [31:0] data3;
  logic [31:0] pending;

  rf_write_arbiter_if mif();

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk         (clk),
    .reset       (reset),
    .p_wr        (p_wr),
    .p_addr      (p_addr),
    .p_data      (p_data),
    .mdu         (mif),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rd_addr     (rd_addr),
    .stall       (stall),
    .p_hold      (p_hold),
    .wr          (wr),
    .addr3       (addr3),
    .data3       (data3),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  ent_t        mq[$];
  ent_t        exp_q[$];
  logic [31:0] mpend;
  int          mcnt;
  logic        mhold;
  // MDU source: holds its result until accepted
  logic        mv;
  logic [4:0]  ma;
  logic [31:0] md;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    mpend = 32'd0;
    mcnt  = 0;
    mhold = 1'b0;
  endtask

  // One cycle: entered just after a rising edge, returns just after the next one.
  task automatic step(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                      input logic iv, input logic [4:0] ia,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    logic pop, rdy, stl, nhold;
    p_wr = pw; p_addr = pa; p_data = pd;
    issue_valid = iv; issue_addr = ia;
    rs_addr = rs; rt_addr = rt; rd_addr = rd;
    mif.m_valid = mv; mif.m_addr = ma; mif.m_data = md;
    pop = !pw && (mq.size() > 0);
    if (pw) exp_q.push_back('{a: pa, d: pd});
    else if (pop) exp_q.push_back(mq[0]);
    rdy = (mq.size() < DEPTH) || pop;
    stl = mpend[rs] | mpend[rt] | mpend[rd];
    @(negedge clk);
    chk("m_ready", {31'd0, mif.m_ready}, {31'd0, rdy});
    chk("stall", {31'd0, stall}, {31'd0, stl});
    chk("pending", pending, mpend);
    chk("p_hold", {31'd0, p_hold}, {31'd0, mhold});
    chk("wr", {31'd0, wr}, {31'd0, (pw || pop)});
    if (!(pw || pop)) begin
      chk("idle_addr3", {27'd0, addr3}, 32'd0);
      chk("idle_data3", data3, 32'd0);
    end
    @(posedge clk);
    nhold = (mcnt == LIMIT);
    if (mq.size() == 0 || pop || mcnt == LIMIT) mcnt = 0;
    else mcnt = mcnt + 1;
    mhold = nhold;
    if (pop) begin
      if (mq[0].a != 5'd0) mpend[mq[0].a] = 1'b0;
      void'(mq.pop_front());
    end
    if (iv && ia != 5'd0) mpend[ia] = 1'b1;
    if (mv && rdy) begin
      mq.push_back('{a: ma, d: md});
      mv = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic mdu_load(input logic [4:0] a, input logic [31:0] d);
    mv = 1'b1; ma = a; md = d;
  endtask

  // Write monitor: every DUT write must match the next expected write, in order.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (wr === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write addr3=%0d data3=%h t=%0t", addr3, data3, $time);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", {27'd0, addr3}, {27'd0, e.a});
          chk("write_data", data3, e.d);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    p_wr = 1'b0; p_addr = 5'd0; p_data = 32'd0;
    issue_valid = 1'b0; issue_addr = 5'd0;
    rs_addr = 5'd0; rt_addr = 5'd0; rd_addr = 5'd0;
    mif.m_valid = 1'b0; mif.m_addr = 5'd0; mif.m_data = 32'd0;
    mv = 1'b0; ma = 5'd0; md = 32'd0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr", {31'd0, wr}, 32'd0);
    chk("rst_m_ready", {31'd0, mif.m_ready}, 32'd1);
    chk("rst_pending", pending, 32'd0);
    chk("rst_p_hold", {31'd0, p_hold}, 32'd0);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    // Hazard with empty scoreboard, then idle drain of $8
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd0, 5'd0, 5'd0);
    mdu_load(5'd8, 32'h12345678);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd8, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd8, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd8, 5'd0, 5'd0);

    // Priority and buffering: pipeline owns the port while $9,$10 fill the FIFO
    mdu_load(5'd9, 32'h99990009);
    step(1'b1, 5'd3, 32'h33330001, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    mdu_load(5'd10, 32'hAAAA000A);
    step(1'b1, 5'd3, 32'h33330002, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    mdu_load(5'd11, 32'hBBBB000B);
    step(1'b1, 5'd3, 32'h33330003, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    idle(4);

    // Hazard stall on rs and rd
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd5);

    // Starvation: one buffered result blocked by continuous writeback
    mdu_load(5'd12, 32'hC0C0C0C0);
    step(1'b1, 5'd4, 32'h44440000, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 5'd4, 32'h44440001 + i, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    idle(2);

    // Set/clear collision on $7
    step(1'b1, 5'd2, 32'h22220000, 1'b1, 5'd7, 5'd0, 5'd0, 5'd0);
    mdu_load(5'd7, 32'h77777777);
    step(1'b1, 5'd2, 32'h22220001, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0, 5'd0);

    // Randomized traffic with alternating light and heavy writeback phases
    begin
      logic heavy;
      heavy = 1'b0;
      for (int c = 0; c < 1500; c++) begin
        if (c % 40 == 0) heavy = ($urandom_range(0, 1) == 1);
        if (!mv && $urandom_range(0, 2) != 0) mdu_load(5'($urandom_range(0, 31)), $urandom);
        step(heavy ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0),
             5'($urandom_range(0, 31)), $urandom,
             ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end
    end
    mv = 1'b0;
    idle(4);

    // Reset mid-operation: full FIFO and pending bits, reset dropped between edges
    step(1'b1, 5'd1, 32'h11110000, 1'b1, 5'd20, 5'd0, 5'd0, 5'd0);
    mdu_load(5'd20, 32'h20202020);
    step(1'b1, 5'd1, 32'h11110001, 1'b1, 5'd21, 5'd0, 5'd0, 5'd0);
    mdu_load(5'd21, 32'h21212121);
    step(1'b1, 5'd1, 32'h11110002, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    p_wr = 1'b0; issue_valid = 1'b0; rs_addr = 5'd20;
    mif.m_valid = 1'b1; mif.m_addr = 5'd22; mif.m_data = 32'h22222222;
    #2 reset = 1'b0;
    #1;
    chk("midrst_wr", {31'd0, wr}, 32'd0);
    chk("midrst_addr3", {27'd0, addr3}, 32'd0);
    chk("midrst_data3", data3, 32'd0);
    chk("midrst_m_ready", {31'd0, mif.m_ready}, 32'd1);
    chk("midrst_pending", pending, 32'd0);
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_p_hold", {31'd0, p_hold}, 32'd0);
    model_clear();
    mv = 1'b0;
    mif.m_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    idle(4);

    chk("leftover_writes", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port between the pipeline writeback stage and the multi-cycle mult/div unit (MDU). The block buffers MDU results in a small FIFO and drains them into idle writeback slots. It keeps a per-register pending scoreboard so decode stalls on hazards against outstanding MDU results. It also raises a hold request when MDU results are starved. It sits between writeback/MDU and the register file's `wr`/`addr3`/`data3` inputs.

## Interface
- `DEPTH`, 2: MDU result FIFO entries (power of two, ≥2).
- `STARVE_LIMIT`, 4: consecutive blocked-drain cycles before `p_hold` asserts (≥1).

- `clk` in 1: clock, rising edge.
- `reset` in 1: reset; asynchronous, active-low.
- `p_wr` in 1: pipeline writeback request.
- `p_addr` in 5: pipeline writeback register.
- `p_data` in 32: pipeline writeback data.
- `m_valid` in 1: MDU result valid.
- `m_ready` out 1: MDU result accepted this cycle.
- `m_addr` in 5: MDU result register.
- `m_data` in 32: MDU result data.
- `issue_valid` in 1: an MDU op issues this cycle.
- `issue_addr` in 5: destination of the issuing op.
- `rs_addr`, `rt_addr`, `rd_addr` in 5 each: decode-stage operand and destination registers.
- `stall` out 1: decode hazard against a pending register.
- `p_hold` out 1: request to freeze the pipeline for one cycle so the FIFO can drain.
- `wr` out 1: register-file write enable.
- `addr3` out 5: register-file write address.
- `data3` out 32: register-file write data.
- `pending` out 32: scoreboard; bit 0 is always 0.

## Operation
- **Write-port mux (combinational):**
  - If `p_wr`: `wr=1`, `addr3=p_addr`, `data3=p_data`.
  - Else if the FIFO is non-empty: `wr=1`, and `addr3`/`data3` come from the FIFO head; the head pops at the clock edge.
  - Else `wr=0`, `addr3=0`, `data3=0`.
  - The pipeline always has priority.
- **FIFO handshake:**
  - `m_ready = !full || pop_this_cycle`.
  - A push occurs when `m_valid && m_ready`.
  - Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
  - MDU results never bypass the FIFO.
- **Scoreboard:**
  - On `issue_valid && issue_addr!=0`, `pending[issue_addr]` is set.
  - On a FIFO pop, `pending[head addr]` is cleared.
  - Set and clear of the same bit in the same cycle: set wins.
  - A pipeline write does not touch `pending`.
- **Stall:** `stall = pending[rs_addr] | pending[rt_addr] | pending[rd_addr]` (combinational). Index 0 is never pending. The `rd_addr` term blocks WAW and double issue to the same register.
- **Starvation counter:**
  - Increments each cycle that the FIFO is non-empty and `p_wr=1`.
  - Resets to 0 on any pop, or when the FIFO is empty.
  - Saturates at `STARVE_LIMIT`.
  - `p_hold` is registered. It asserts for exactly one cycle when the counter reaches `STARVE_LIMIT`, then the counter clears.
  - The pipeline is required to keep `p_wr=0` in the cycle after `p_hold`. If `p_wr=1` anyway, the pipeline still wins and no error is flagged.
- **Reset (async, mid-operation included):**
  - FIFO empty, all `pending` bits 0, counter 0, `p_hold=0`.
  - Outputs during reset: `wr=0`, `addr3=0`, `data3=0`, `m_ready=1`, `stall=0`.
  - Any in-flight MDU results are discarded.

## Timing
- MDU result accepted at edge k is written, at the earliest, by the write committed at edge k+1, provided `p_wr=0` in cycle k+1.
- `pending` updates one edge after issue. `stall` reflects the new bit in the following cycle. The issue cycle itself must not rely on `stall`.
- The pending clear is visible in the cycle after the pop edge. The register file's internal write-through covers the pop cycle itself.
- `p_hold` rises one cycle after the counter reaches `STARVE_LIMIT` and lasts one cycle.
- Full FIFO with no pop: `m_ready=0`. MDU holds `m_addr`/`m_data` stable while `m_valid` is high.

## Structure
- **Package `rf_arb_pkg`:** `REG_AW=5`, `DATA_W=32`, default `DEPTH` and `STARVE_LIMIT`, and the FIFO entry type {addr, data}.
- **Sub-module `rf_result_fifo`:** DEPTH-entry synchronous FIFO.
  - Signals: push, pop, full, empty, head.
  - Read and write pointers wrap modulo DEPTH; an occupancy counter disambiguates full from empty.
- The top level holds the mux, scoreboard, starvation counter and stall logic.

## Test plan
- **Idle drain:** reset, issue to $8, then `m_valid` with $8=0x12345678 and `p_wr=0` → `m_ready=1`; the next cycle has `wr=1`, `addr3=8`, `data3=0x12345678`; `pending[8]` returns to 0 the cycle after.
- **Priority and buffering:** `p_wr=1` to $3 for 3 cycles while the MDU pushes $9 and $10 → `m_ready` drops to 0 after 2 pushes; writes $9 then $10 follow in the first two cycles with `p_wr=0`, in FIFO order.
- **Starvation:** FIFO non-empty with `p_wr=1` continuously, `STARVE_LIMIT=4` → `p_hold` pulses high exactly one cycle after 4 blocked cycles; with `p_wr=0` in the hold cycle the head drains.
- **Hazard stall:** `pending[5]=1`, decode `rs_addr=5` → `stall=1`; `rt_addr=0` alone with `pending` empty → `stall=0`; `rd_addr=5` → `stall=1`.
- **Set/clear collision:** pop of $7 in the same cycle as `issue_valid`, `issue_addr=7` → `pending[7]` remains 1.
- **Reset mid-operation:** FIFO full and `pending` bits set, then assert `reset` asynchronously between edges → `wr=0`, `pending=0`, `m_ready=1` immediately; after release, no stale writes appear.
